frame_header_encoder: RTL and testbench

Transmit-side framer for the ICE frame buffer: accepts a packet request (type, EID, length) plus a byte stream and writes complete frames into the shared 512-word, 9-bit circular frame buffer. It produces exactly the layout the frame header decoder consumes:

- word 0: type
- word 1: EID
- word 2: length byte (0x00 empty, 0xFF non-final fragment)
- payload, with bit 8 marking the last word

The write pointer is published only after a whole frame is in memory, so the reader never sees a partial frame.

---
 rtl/frame_enc_pkg.sv | 36 +++
 rtl/frame_space_check.sv | 23 ++
 rtl/frame_header_encoder.sv | 221 ++++++++++++++++++++++
 tb/tb_frame_header_encoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_enc_pkg.sv
// Shared definitions for the frame header encoder: state encoding, buffer
// geometry, header constants and the per-frame length helper.
package frame_enc_pkg;

    localparam int FRAME_WORD_W = 9;
    localparam int FRAME_ADDR_W = 9;
    localparam int HDR_WORDS    = 3;

    localparam logic [7:0]              LEN_EMPTY = 8'h00;
    localparam logic [7:0]              LEN_FRAG  = 8'hFF;
    localparam logic [FRAME_WORD_W-1:0] TERM_WORD = 9'h100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SPACE   = 3'd1,
        ST_WR_TYPE = 3'd2,
        ST_WR_EID  = 3'd3,
        ST_WR_LEN  = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_WR_TERM = 3'd6,
        ST_COMMIT  = 3'd7
    } enc_state_t;

    // Payload bytes carried by the next frame: the remainder, capped at max_frag.
    function automatic logic [7:0] calc_frag_len(input logic [10:0] remaining,
                                                 input logic [7:0]  max_frag);
        logic [7:0] result;
        if (remaining > {3'b000, max_frag}) begin
            result = max_frag;
        end else begin
            result = remaining[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_space_check.sv
// Combinational free-space test for the circular frame buffer. All pointer
// arithmetic is modulo 512; one word is always left unused so that a full
// buffer is distinguishable from an empty one.
module frame_space_check
    import frame_enc_pkg::*;
(
    input  logic [FRAME_ADDR_W-1:0] i_wr_base,
    input  logic [FRAME_ADDR_W-1:0] i_frame_tail,
    input  logic [7:0]              i_frag_len,
    output logic                    o_space_ok
);

    logic [FRAME_ADDR_W-1:0] w_used;
    logic [FRAME_ADDR_W-1:0] w_free;
    logic [FRAME_ADDR_W-1:0] w_need;

    assign w_used = i_wr_base - i_frame_tail;
    assign w_free = 9'd511 - w_used;
    // An empty frame still needs its terminator word.
    assign w_need = 9'(HDR_WORDS) + ((i_frag_len == 8'd0) ? 9'd1 : {1'b0, i_frag_len});
    assign o_space_ok = (w_free >= w_need);

endmodule

// File: rtl/frame_header_encoder.sv
// Transmit-side framer: writes type/EID/length header plus payload into the
// shared circular frame buffer and publishes the head only after a whole
// frame is in memory.
// Build option: define FRAME_ENC_FRAGMENT_EN to split requests longer than
// MAX_FRAG into several frames; otherwise such requests are rejected.
module frame_header_encoder
    import frame_enc_pkg::*;
#(
    parameter int MAX_FRAG = 64
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_start,
    output logic                    in_start_ready,
    input  logic [7:0]              in_type,
    input  logic [7:0]              in_eid,
    input  logic [10:0]             in_len,
    input  logic [7:0]              in_data,
    input  logic                    in_data_valid,
    output logic                    in_data_ready,
    input  logic [FRAME_ADDR_W-1:0] in_frame_tail,
    output logic [FRAME_ADDR_W-1:0] out_frame_addr,
    output logic [FRAME_WORD_W-1:0] out_frame_data,
    output logic                    out_frame_we,
    output logic [FRAME_ADDR_W-1:0] out_frame_head,
    output logic                    frame_done,
    output logic                    len_err,
    output logic                    busy
);

    localparam logic [7:0]  MAX_FRAG_B = 8'(MAX_FRAG);
    localparam logic [10:0] MAX_FRAG_L = 11'(MAX_FRAG);

    enc_state_t r_state;
    enc_state_t w_next_state;

    logic [7:0]              r_type;
    logic [7:0]              r_eid;
    logic [10:0]             r_remaining;
    logic [FRAME_ADDR_W-1:0] r_wr_base;
    logic [FRAME_ADDR_W-1:0] r_offset;
    logic [FRAME_ADDR_W-1:0] r_head;
    logic                    r_frame_done;
    logic                    r_len_err;
    logic                    r_busy;
    logic                    r_start_ready;
    logic                    r_data_ready;

    logic [7:0]              w_frag_len;
    logic                    w_nonfinal;
    logic                    w_len_bad;
    logic [7:0]              w_len_byte;
    logic                    w_space_ok;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_we;
    logic                    w_final_write;
    logic [FRAME_ADDR_W-1:0] w_addr;
    logic [FRAME_WORD_W-1:0] w_wdata;

    assign w_frag_len = calc_frag_len(r_remaining, MAX_FRAG_B);

`ifdef FRAME_ENC_FRAGMENT_EN
    assign w_len_bad  = 1'b0;
    assign w_nonfinal = (r_remaining > MAX_FRAG_L);
`else
    assign w_len_bad  = (in_len > MAX_FRAG_L);
    assign w_nonfinal = 1'b0;
`endif

    assign w_len_byte = w_nonfinal ? LEN_FRAG :
                        ((r_remaining == 11'd0) ? LEN_EMPTY : r_remaining[7:0]);

    // Payload byte k (1-based) sits at offset 2+k, so the last one is at 2+frag_len.
    assign w_last   = (r_offset == ({1'b0, w_frag_len} + 9'd2));
    assign w_accept = (r_state == ST_IDLE) && in_start;
    assign w_addr   = r_wr_base + r_offset;

    frame_space_check u_space (
        .i_wr_base    (r_wr_base),
        .i_frame_tail (in_frame_tail),
        .i_frag_len   (w_frag_len),
        .o_space_ok   (w_space_ok)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and the buffer write port for the current state.
    always_comb begin
        w_next_state  = r_state;
        w_we          = 1'b0;
        w_wdata       = 9'h000;
        w_final_write = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_start) begin
                    if (w_len_bad) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_SPACE;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SPACE: begin
                if (w_space_ok) begin
                    w_next_state = ST_WR_TYPE;
                end else begin
                    w_next_state = ST_SPACE;
                end
            end
            ST_WR_TYPE: begin
                w_we         = 1'b1;
                w_wdata      = {1'b0, r_type};
                w_next_state = ST_WR_EID;
            end
            ST_WR_EID: begin
                w_we         = 1'b1;
                w_wdata      = {1'b0, r_eid};
                w_next_state = ST_WR_LEN;
            end
            ST_WR_LEN: begin
                w_we    = 1'b1;
                w_wdata = {1'b0, w_len_byte};
                if (w_frag_len != 8'd0) begin
                    w_next_state = ST_WR_DATA;
                end else begin
                    w_next_state = ST_WR_TERM;
                end
            end
            ST_WR_DATA: begin
                if (in_data_valid) begin
                    w_we    = 1'b1;
                    w_wdata = {w_last, in_data};
                    if (w_last) begin
                        w_final_write = 1'b1;
                        w_next_state  = ST_COMMIT;
                    end else begin
                        w_next_state  = ST_WR_DATA;
                    end
                end else begin
                    w_next_state = ST_WR_DATA;
                end
            end
            ST_WR_TERM: begin
                w_we          = 1'b1;
                w_wdata       = TERM_WORD;
                w_final_write = 1'b1;
                w_next_state  = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (r_remaining != {3'b000, w_frag_len}) begin
                    w_next_state = ST_SPACE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request latch, offset/base/head bookkeeping and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_type        <= 8'h00;
            r_eid         <= 8'h00;
            r_remaining   <= 11'd0;
            r_wr_base     <= 9'd0;
            r_offset      <= 9'd0;
            r_head        <= 9'd0;
            r_frame_done  <= 1'b0;
            r_len_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
            r_data_ready  <= 1'b0;
        end else begin
            r_start_ready <= (w_next_state == ST_IDLE);
            r_data_ready  <= (w_next_state == ST_WR_DATA);
            r_busy        <= (w_next_state != ST_IDLE);
            r_len_err     <= w_accept && w_len_bad;
            // Head moves with the final write so it is visible alongside frame_done.
            r_frame_done  <= w_final_write;
            if (w_accept) begin
                r_type      <= in_type;
                r_eid       <= in_eid;
                r_remaining <= in_len;
                r_offset    <= 9'd0;
            end else if (w_final_write) begin
                r_offset  <= 9'd0;
                r_wr_base <= w_addr + 9'd1;
                r_head    <= w_addr + 9'd1;
            end else if (w_we) begin
                r_offset <= r_offset + 9'd1;
            end else if (r_state == ST_COMMIT) begin
                r_remaining <= r_remaining - {3'b000, w_frag_len};
            end
        end
    end

    assign in_start_ready = r_start_ready;
    assign in_data_ready  = r_data_ready;
    assign busy           = r_busy;
    assign frame_done     = r_frame_done;
    assign len_err        = r_len_err;
    assign out_frame_head = r_head;
    assign out_frame_addr = w_addr;
    assign out_frame_data = w_wdata;
    assign out_frame_we   = w_we;

endmodule

// File: tb/tb_frame_header_encoder.sv
// Self-checking bench for frame_header_encoder: directed scenarios plus
// randomized requests, compared against a frame-list reference model.
module tb_frame_header_encoder;

    localparam int MAXF = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start;
    logic        in_start_ready;
    logic [7:0]  in_type;
    logic [7:0]  in_eid;
    logic [10:0] in_len;
    logic [7:0]  in_data;
    logic        in_data_valid;
    logic        in_data_ready;
    logic [8:0]  in_frame_tail;
    logic [8:0]  out_frame_addr;
    logic [8:0]  out_frame_data;
    logic        out_frame_we;
    logic [8:0]  out_frame_head;
    logic        frame_done;
    logic        len_err;
    logic        busy;

    always #5 clk = ~clk;

    frame_header_encoder #(.MAX_FRAG(MAXF)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_start       (in_start),
        .in_start_ready (in_start_ready),
        .in_type        (in_type),
        .in_eid         (in_eid),
        .in_len         (in_len),
        .in_data        (in_data),
        .in_data_valid  (in_data_valid),
        .in_data_ready  (in_data_ready),
        .in_frame_tail  (in_frame_tail),
        .out_frame_addr (out_frame_addr),
        .out_frame_data (out_frame_data),
        .out_frame_we   (out_frame_we),
        .out_frame_head (out_frame_head),
        .frame_done     (frame_done),
        .len_err        (len_err),
        .busy           (busy)
    );

    // Buffer model and event counters, sampled mid-cycle.
    int         cyc = 0;
    int         we_cnt = 0;
    int         done_cnt = 0;
    int         lerr_cnt = 0;
    int         rdy_cnt = 0;
    int         acc_cyc = 0;
    int         fwe_cyc = 0;
    int         done_cyc = 0;
    bit         wait_we = 1'b0;
    logic [8:0] mem [0:511];
    int         wstamp [0:511];
    logic [8:0] done_head [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_frame_we) begin
            mem[out_frame_addr]    <= out_frame_data;
            wstamp[out_frame_addr] <= cyc;
            we_cnt                 <= we_cnt + 1;
        end
        if (frame_done) begin
            done_head[done_cnt[7:0]] <= out_frame_head;
            done_cnt                 <= done_cnt + 1;
            done_cyc                 <= cyc;
        end
        if (len_err) lerr_cnt <= lerr_cnt + 1;
        if (in_data_ready) rdy_cnt <= rdy_cnt + 1;
        if (in_start && in_start_ready) begin
            acc_cyc <= cyc;
            wait_we <= 1'b1;
        end else if (out_frame_we && wait_we) begin
            fwe_cyc <= cyc;
            wait_we <= 1'b0;
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         m_base = 0;
    logic [7:0] pay [0:2047];
    logic [8:0] exp_q [$];
    logic [8:0] exp_heads [$];
    bit         exp_rej;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the list of buffer words a request must produce.
    task automatic build_model(input logic [7:0] t, input logic [7:0] e, input int len);
        int rem;
        int fl;
        int p;
        exp_q.delete();
        exp_heads.delete();
`ifdef FRAME_ENC_FRAGMENT_EN
        exp_rej = 1'b0;
`else
        exp_rej = (len > MAXF);
`endif
        if (!exp_rej) begin
            rem = len;
            p   = 0;
            do begin
                fl = (rem < MAXF) ? rem : MAXF;
                exp_q.push_back({1'b0, t});
                exp_q.push_back({1'b0, e});
                if (rem > MAXF) exp_q.push_back(9'h0FF);
                else            exp_q.push_back({1'b0, rem[7:0]});
                if (fl == 0) begin
                    exp_q.push_back(9'h100);
                end else begin
                    for (int k = 0; k < fl; k++) exp_q.push_back({(k == fl - 1), pay[p + k]});
                end
                p   += fl;
                rem -= fl;
                exp_heads.push_back(9'((m_base + exp_q.size()) % 512));
            end while (rem > 0);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_head"}, out_frame_head, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_lerr"}, len_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_we"}, out_frame_we, 0);
        chk({tag, "_drdy"}, in_data_ready, 0);
        chk({tag, "_srdy"}, in_start_ready, 1);
    endtask

    // One request: stall holds the tail 5 words ahead for that many cycles;
    // abort >= 0 asserts rst after that many payload bytes.
    task automatic run_req(input logic [7:0] t, input logic [7:0] e, input int len,
                           input bit bub, input int stall, input int abort, input bit fixed);
        int idx, n, d0, l0, w0, r0, s0, a;
        bit hs, fin, acc;
        logic [8:0] h0, got;
        if (!fixed) for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
        build_model(t, e, len);
        d0 = done_cnt; l0 = lerr_cnt; w0 = we_cnt; r0 = rdy_cnt; s0 = cyc; h0 = out_frame_head;
        in_frame_tail = (stall > 0) ? 9'(m_base + 5) : 9'(m_base);
        in_type = t; in_eid = e; in_len = 11'(len); in_start = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 100) begin
            @(negedge clk); acc = in_start_ready;
            @(posedge clk); #1; n++;
        end
        in_start = 1'b0;
        chk("accept", acc, 1);
        if (stall > 0) begin
            in_data_valid = (len > 0);
            in_data = pay[0];
            repeat (stall) @(posedge clk);
            #1;
            chk("stall_we", we_cnt - w0, 0);
            chk("stall_busy", busy, 1);
            chk("stall_rdy", rdy_cnt - r0, 0);
            in_frame_tail = 9'(m_base + 15);
        end
        idx = 0; n = 0; fin = 1'b0;
        while (!fin && n < 1500) begin
            in_data_valid = (idx < len) && (!bub || $urandom_range(0, 3) != 0);
            in_data = (idx < len) ? pay[idx] : 8'h00;
            @(negedge clk); hs = in_data_valid && in_data_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            n++;
            if (abort >= 0 && idx == abort) break;
            fin = (!exp_rej && (done_cnt - d0) >= exp_heads.size()) || (lerr_cnt != l0);
        end
        in_data_valid = 1'b0;
        if (abort >= 0) begin
            chk("abort_reached", idx, abort);
            rst = 1'b1;
            @(posedge clk); #1;
            chk_reset_state("midrst");
            in_frame_tail = 9'd0;
            rst = 1'b0;
            m_base = 0;
            return;
        end
        chk("finish", fin, 1);
        repeat (2) @(posedge clk);
        #1;
        if (exp_rej) begin
            chk("rej_lerr", lerr_cnt - l0, 1);
            chk("rej_we", we_cnt - w0, 0);
            chk("rej_rdy", rdy_cnt - r0, 0);
            chk("rej_head", out_frame_head, h0);
            chk("rej_busy", busy, 0);
        end else begin
            chk("lerr_none", lerr_cnt - l0, 0);
            chk("frames", done_cnt - d0, exp_heads.size());
            chk("we_count", we_cnt - w0, exp_q.size());
            chk("consumed", idx, len);
            for (int i = 0; i < exp_q.size(); i++) begin
                a = (m_base + i) % 512;
                got = (wstamp[a] >= s0) ? mem[a] : 9'bx;
                chk("word", got, exp_q[i]);
            end
            for (int i = 0; i < exp_heads.size(); i++)
                chk("head_at_done", done_head[(d0 + i) & 255], exp_heads[i]);
            chk("head_out", out_frame_head, exp_heads[exp_heads.size() - 1]);
            m_base = (m_base + exp_q.size()) % 512;
        end
    endtask

    initial begin
        int d;
        rst = 1'b1; in_start = 1'b0; in_type = 8'h00; in_eid = 8'h00; in_len = 11'd0;
        in_data = 8'h00; in_data_valid = 1'b0; in_frame_tail = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_srdy", in_start_ready, 1);

        // Three-byte frame with fixed payload and latency check.
        pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
        run_req(8'h10, 8'h22, 3, 1'b0, 0, -1, 1'b1);
        chk("t1_w0", mem[0], 9'h010);
        chk("t1_w2", mem[2], 9'h003);
        chk("t1_w5", mem[5], 9'h1A3);
        chk("t1_head", out_frame_head, 9'd6);
        chk("t1_first_write_lat", fwe_cyc - acc_cyc, 2);
        chk("t1_done_lat", done_cyc - acc_cyc, 8);

        // Empty packet.
        run_req(8'h7E, 8'h05, 0, 1'b0, 0, -1, 1'b0);
        chk("t2_eid", mem[7], 9'h005);
        chk("t2_len", mem[8], 9'h000);
        chk("t2_term", mem[9], 9'h100);
        chk("t2_head", out_frame_head, 9'd10);

`ifdef FRAME_ENC_FRAGMENT_EN
        run_req(8'h21, 8'h31, 150, 1'b1, 0, -1, 1'b0);
        chk("frag_len1", mem[12], 9'h0FF);
        chk("frag_len2", mem[79], 9'h0FF);
        chk("frag_len3", mem[146], 9'h016);
        chk("frag_head", out_frame_head, 9'd169);
`else
        run_req(8'h21, 8'h31, 100, 1'b1, 0, -1, 1'b0);
`endif

        // Randomized requests with payload bubbles.
        for (int i = 0; i < 12; i++)
            run_req(8'($urandom), 8'($urandom), $urandom_range(0, MAXF + 16), 1'b1, 0, -1, 1'b0);

        // Bring the head to 508 so the stalled frame wraps past 511.
        d = (508 - m_base + 512) % 512;
        while (d < 4 || d > 67) begin
            run_req(8'h01, 8'h02, MAXF, 1'b0, 0, -1, 1'b0);
            d = (508 - m_base + 512) % 512;
        end
        run_req(8'h03, 8'h04, d - 3, 1'b0, 0, -1, 1'b0);
        chk("fill_head", out_frame_head, 9'd508);
        run_req(8'h33, 8'h44, 4, 1'b0, 20, -1, 1'b0);
        chk("wrap_head", out_frame_head, 9'd3);
        chk("wrap_w511", mem[511], 9'h000 | {1'b0, pay[0]});

        // Reset in the middle of a frame, then a fresh frame from address 0.
        run_req(8'h66, 8'h77, 8, 1'b0, 0, 2, 1'b0);
        run_req(8'h5A, 8'hA5, 3, 1'b0, 0, -1, 1'b0);
        chk("after_rst_w0", mem[0], 9'h05A);
        chk("after_rst_head", out_frame_head, 9'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
